// File: rtl/rob_pkg.sv
// Reorder-buffer shared types: entry layout, empty entry and tag age helper.
package rob_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_MAX_W = 8;

  // For stores, done means the store data is present; addr_ok tracks the address.
  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      npc;
    logic [31:0]          inst;
    logic                 wr_mem;
    logic                 is_branch;
    logic [4:0]           dest_reg;
    logic [XLEN-1:0]      dest_addr;
    logic [XLEN-1:0]      value;
    logic [TAG_MAX_W-1:0] store_dep;
    logic [2:0]           mem_size;
    logic                 done;
    logic                 addr_ok;
    logic                 br_ok;
  } ROB_ENTRY;

  localparam ROB_ENTRY EMPTY_ROB_ENTRY = '0;

  // True when tag a sits closer to head than tag b; mask = DEPTH-1.
  function automatic logic tag_older(input logic [TAG_MAX_W-1:0] a,
                                     input logic [TAG_MAX_W-1:0] b,
                                     input logic [TAG_MAX_W-1:0] head,
                                     input logic [TAG_MAX_W-1:0] mask);
    logic [TAG_MAX_W-1:0] pa;
    logic [TAG_MAX_W-1:0] pb;
    pa = (a - head) & mask;
    pb = (b - head) & mask;
    return pa < pb;
  endfunction

endpackage

// File: rtl/rob_flush_age_mask.sv
// Per-entry age relative to a reference tag: older = between head and ref, younger = after ref up to tail.
module rob_age_mask
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic [TAG_W:0]   head,
  input  logic [TAG_W:0]   tail,
  input  logic [TAG_W-1:0] ref_tag,
  output logic [DEPTH-1:0] younger,
  output logic [DEPTH-1:0] older
);

  logic [TAG_W:0]   occ;
  logic [TAG_W-1:0] pos_r;
  logic [TAG_W-1:0] pos [DEPTH];

  assign occ   = tail - head;
  assign pos_r = ref_tag - head[TAG_W-1:0];

  always_comb begin
    younger = '0;
    older   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos[i]     = TAG_W'(i) - head[TAG_W-1:0];
      older[i]   = tag_older(TAG_MAX_W'(i), TAG_MAX_W'(ref_tag),
                             TAG_MAX_W'(head[TAG_W-1:0]), TAG_MAX_W'(DEPTH - 1));
      younger[i] = ({1'b0, pos[i]} < occ) && (pos[i] > pos_r);
    end
  end

endmodule

// File: rtl/rob_flush.sv
// Reorder buffer: in-order alloc/commit, out-of-order CDB completion, precise mispredict squash.
module rob_flush
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned N_CDB = 2,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [31:0]           alloc_inst,
  input  logic [XLEN-1:0]       alloc_npc,
  input  logic [4:0]            alloc_dest_reg,
  input  logic                  alloc_wr_mem,
  input  logic                  alloc_is_branch,
  input  logic [2:0]            alloc_mem_size,
  input  logic [XLEN-1:0]       alloc_val,
  input  logic                  alloc_val_ok,
  input  logic [TAG_W-1:0]      alloc_store_dep,
  output logic [TAG_W-1:0]      alloc_tag,
  input  logic [N_CDB-1:0]      cdb_valid,
  input  logic [N_CDB*TAG_W-1:0] cdb_tag,
  input  logic [N_CDB*XLEN-1:0] cdb_value,
  input  logic                  br_valid,
  input  logic [TAG_W-1:0]      br_tag,
  input  logic                  br_mispredict,
  input  logic [TAG_W-1:0]      rd_tag_rs1,
  input  logic [TAG_W-1:0]      rd_tag_rs2,
  output logic [XLEN-1:0]       rd_val_rs1,
  output logic [XLEN-1:0]       rd_val_rs2,
  output logic                  rd_ok_rs1,
  output logic                  rd_ok_rs2,
  input  logic [TAG_W-1:0]      ld_tag,
  input  logic [XLEN-1:0]       ld_addr,
  output logic                  ld_blocked,
  output logic                  commit_valid,
  input  logic                  commit_ready,
  output ROB_ENTRY              commit_entry,
  output logic [TAG_W:0]        count
);

  ROB_ENTRY         rob   [DEPTH];
  ROB_ENTRY         rob_n [DEPTH];
  logic [TAG_W:0]   head, tail, head_n, tail_n;
  logic [TAG_W-1:0] head_idx, tail_idx, pos_br;
  logic [TAG_W-1:0] cdb_tag_a [N_CDB];
  logic [XLEN-1:0]  cdb_val_a [N_CDB];
  logic [DEPTH-1:0] flush_younger, flush_older, ld_younger, ld_older, squash;
  logic             flush_now, full, alloc_fire, commit_fire, fwd_ok;
  logic [XLEN-1:0]  fwd_val;
  logic [TAG_W-1:0] rd_tag [2];
  logic [XLEN-1:0]  rd_val [2];
  logic             rd_ok  [2];

  assign head_idx    = head[TAG_W-1:0];
  assign tail_idx    = tail[TAG_W-1:0];
  assign count       = tail - head;
  assign full        = (count == (TAG_W+1)'(DEPTH));
  assign flush_now   = br_valid && br_mispredict;
  assign alloc_ready = !full && !flush_now;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_idx;
  assign squash      = flush_now ? flush_younger : '0;
  assign pos_br      = br_tag - head_idx;

  assign commit_entry = rob[head_idx];
  assign commit_valid = rob[head_idx].valid && rob[head_idx].done &&
                        rob[head_idx].addr_ok && rob[head_idx].br_ok;
  assign commit_fire  = commit_valid && commit_ready;

  rob_age_mask #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_flush_mask (
    .head(head), .tail(tail), .ref_tag(br_tag), .younger(flush_younger), .older(flush_older)
  );

  rob_age_mask #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_ld_mask (
    .head(head), .tail(tail), .ref_tag(ld_tag), .younger(ld_younger), .older(ld_older)
  );

  always_comb begin
    for (int p = 0; p < N_CDB; p++) begin
      cdb_tag_a[p] = cdb_tag[p*TAG_W +: TAG_W];
      cdb_val_a[p] = cdb_value[p*XLEN +: XLEN];
    end
  end

  // Store data at dispatch: explicit value, ready producer entry, or same-cycle CDB.
  always_comb begin
    fwd_ok  = alloc_val_ok;
    fwd_val = alloc_val;
    if (!alloc_val_ok && rob[alloc_store_dep].valid) begin
      if (rob[alloc_store_dep].done && !rob[alloc_store_dep].wr_mem) begin
        fwd_ok  = 1'b1;
        fwd_val = rob[alloc_store_dep].value;
      end
      for (int p = 0; p < N_CDB; p++) begin
        if (cdb_valid[p] && cdb_tag_a[p] == alloc_store_dep) begin
          fwd_ok  = 1'b1;
          fwd_val = cdb_val_a[p];
        end
      end
    end
  end

  // Next-state for entries and pointers; later writes take precedence.
  always_comb begin
    rob_n  = rob;
    head_n = head;
    tail_n = tail;
    for (int p = 0; p < N_CDB; p++) begin
      if (cdb_valid[p]) begin
        if (rob[cdb_tag_a[p]].valid && !squash[cdb_tag_a[p]]) begin
          if (rob[cdb_tag_a[p]].wr_mem) begin
            rob_n[cdb_tag_a[p]].dest_addr = cdb_val_a[p];
            rob_n[cdb_tag_a[p]].addr_ok   = 1'b1;
          end else begin
            rob_n[cdb_tag_a[p]].value = cdb_val_a[p];
            rob_n[cdb_tag_a[p]].done  = 1'b1;
          end
        end
        for (int e = 0; e < DEPTH; e++) begin
          if (rob[e].valid && rob[e].wr_mem && !rob[e].done && !squash[e] &&
              rob[e].store_dep == TAG_MAX_W'(cdb_tag_a[p])) begin
            rob_n[e].value = cdb_val_a[p];
            rob_n[e].done  = 1'b1;
          end
        end
      end
    end
    if (br_valid && rob[br_tag].valid)
      rob_n[br_tag].br_ok = 1'b1;
    if (commit_fire) begin
      rob_n[head_idx] = EMPTY_ROB_ENTRY;
      head_n          = head + (TAG_W+1)'(1);
    end
    if (flush_now) begin
      for (int e = 0; e < DEPTH; e++)
        if (flush_younger[e]) rob_n[e] = EMPTY_ROB_ENTRY;
      tail_n = head + (TAG_W+1)'(pos_br) + (TAG_W+1)'(1);
    end
    if (alloc_fire) begin
      rob_n[tail_idx] = '{valid:     1'b1,
                          npc:       alloc_npc,
                          inst:      alloc_inst,
                          wr_mem:    alloc_wr_mem,
                          is_branch: alloc_is_branch,
                          dest_reg:  alloc_dest_reg,
                          dest_addr: '0,
                          value:     alloc_wr_mem ? fwd_val : '0,
                          store_dep: TAG_MAX_W'(alloc_store_dep),
                          mem_size:  alloc_mem_size,
                          done:      alloc_wr_mem && fwd_ok,
                          addr_ok:   !alloc_wr_mem,
                          br_ok:     !alloc_is_branch};
      tail_n = tail + (TAG_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      for (int e = 0; e < DEPTH; e++) rob[e] <= EMPTY_ROB_ENTRY;
    end else begin
      head <= head_n;
      tail <= tail_n;
      for (int e = 0; e < DEPTH; e++) rob[e] <= rob_n[e];
    end
  end

  // Operand lookup with same-cycle CDB bypass.
  assign rd_tag[0] = rd_tag_rs1;
  assign rd_tag[1] = rd_tag_rs2;
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rd_val[k] = rob[rd_tag[k]].value;
      rd_ok[k]  = rob[rd_tag[k]].valid && rob[rd_tag[k]].done;
      for (int p = 0; p < N_CDB; p++) begin
        if (cdb_valid[p] && cdb_tag_a[p] == rd_tag[k] && rob[rd_tag[k]].valid) begin
          rd_val[k] = cdb_val_a[p];
          rd_ok[k]  = 1'b1;
        end
      end
    end
  end
  assign rd_val_rs1 = rd_val[0];
  assign rd_val_rs2 = rd_val[1];
  assign rd_ok_rs1  = rd_ok[0];
  assign rd_ok_rs2  = rd_ok[1];

  always_comb begin
    ld_blocked = 1'b0;
    if (rob[ld_tag].valid && ld_tag != head_idx) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ld_older[e] && rob[e].valid && rob[e].wr_mem &&
            (!rob[e].addr_ok || rob[e].dest_addr == ld_addr))
          ld_blocked = 1'b1;
      end
    end
  end

  // Older and younger sets relative to any tag are always disjoint.
  assert property (@(posedge clock) disable iff (reset)
    ((flush_older & flush_younger) == '0) && ((ld_older & ld_younger) == '0));

endmodule

// File: tb/tb_rob_flush.sv
// Directed bench for rob_flush: fill, commit, CDB ports, branches, wrap, load blocking, reset.
module tb_rob_flush;
  import rob_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned N_CDB = 2;
  localparam int unsigned TAG_W = 3;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    alloc_valid, alloc_ready;
  logic [31:0]             alloc_inst;
  logic [XLEN-1:0]         alloc_npc;
  logic [4:0]              alloc_dest_reg;
  logic                    alloc_wr_mem, alloc_is_branch, alloc_val_ok;
  logic [2:0]              alloc_mem_size;
  logic [XLEN-1:0]         alloc_val;
  logic [TAG_W-1:0]        alloc_store_dep, alloc_tag;
  logic [N_CDB-1:0]        cdb_valid;
  logic [N_CDB*TAG_W-1:0]  cdb_tag;
  logic [N_CDB*XLEN-1:0]   cdb_value;
  logic                    br_valid, br_mispredict;
  logic [TAG_W-1:0]        br_tag, rd_tag_rs1, rd_tag_rs2, ld_tag;
  logic [XLEN-1:0]         rd_val_rs1, rd_val_rs2, ld_addr;
  logic                    rd_ok_rs1, rd_ok_rs2, ld_blocked;
  logic                    commit_valid, commit_ready;
  ROB_ENTRY                commit_entry;
  logic [TAG_W:0]          count;

  int total = 0;
  int bad   = 0;

  rob_flush #(.DEPTH(DEPTH), .N_CDB(N_CDB)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_inst(alloc_inst),
    .alloc_npc(alloc_npc), .alloc_dest_reg(alloc_dest_reg), .alloc_wr_mem(alloc_wr_mem),
    .alloc_is_branch(alloc_is_branch), .alloc_mem_size(alloc_mem_size), .alloc_val(alloc_val),
    .alloc_val_ok(alloc_val_ok), .alloc_store_dep(alloc_store_dep), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict),
    .rd_tag_rs1(rd_tag_rs1), .rd_tag_rs2(rd_tag_rs2), .rd_val_rs1(rd_val_rs1),
    .rd_val_rs2(rd_val_rs2), .rd_ok_rs1(rd_ok_rs1), .rd_ok_rs2(rd_ok_rs2),
    .ld_tag(ld_tag), .ld_addr(ld_addr), .ld_blocked(ld_blocked),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_entry(commit_entry),
    .count(count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_inst = 32'h0000_0013; alloc_npc = '0; alloc_dest_reg = 5'd1;
    alloc_wr_mem = 0; alloc_is_branch = 0; alloc_mem_size = 3'd2; alloc_val = '0;
    alloc_val_ok = 0; alloc_store_dep = '0; cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    br_valid = 0; br_tag = '0; br_mispredict = 0; rd_tag_rs1 = '0; rd_tag_rs2 = '0;
    ld_tag = '0; ld_addr = '0; commit_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic alloc(input logic st, input logic br, input logic vok,
                       input logic [TAG_W-1:0] dep, input logic [XLEN-1:0] v,
                       output logic [TAG_W-1:0] tg);
    alloc_valid = 1; alloc_wr_mem = st; alloc_is_branch = br; alloc_val_ok = vok;
    alloc_store_dep = dep; alloc_val = v;
    #1 tg = alloc_tag;
    tick();
    alloc_valid = 0;
  endtask

  task automatic cdb1(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
    cdb_valid = 2'b01; cdb_tag = {3'd0, t}; cdb_value = {32'd0, v};
    tick();
    cdb_valid = '0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL reset_commit_valid: got %b want 0", commit_valid); end
    total++; if (ld_blocked !== 1'b0) begin bad++; $display("FAIL reset_ld_blocked: got %b want 0", ld_blocked); end
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready); end
  endtask

  task automatic test_fill();
    logic [TAG_W-1:0] tg;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(0, 0, 1, 0, 0, tg);
      total++; if (tg !== TAG_W'(i)) begin bad++; $display("FAIL fill_tag%0d: got %0d want %0d", i, tg, i); end
    end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count: got %0d want 8", count); end
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL fill_alloc_ready: got %b want 0", alloc_ready); end
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL fill_commit_valid: got %b want 0", commit_valid); end
  endtask

  task automatic test_commit();
    cdb1(3'd0, 32'h55);
    total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL commit_valid0: got %b want 1", commit_valid); end
    total++; if (commit_entry.value !== 32'h55) begin bad++; $display("FAIL commit_value0: got %0h want 55", commit_entry.value); end
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_commit_alloc_ready: got %b want 0", alloc_ready); end
    commit_ready = 1;
    tick();
    commit_ready = 0;
    total++; if (count !== 4'd7) begin bad++; $display("FAIL commit_count: got %0d want 7", count); end
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL commit_head1_pending: got %b want 0", commit_valid); end
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL commit_alloc_ready: got %b want 1", alloc_ready); end
    cdb1(3'd1, 32'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (commit_valid !== 1'b1 || commit_entry.value !== 32'h11 || count !== 4'd7) begin
        bad++; $display("FAIL hold%0d: got valid=%b value=%0h count=%0d want 1/11/7", i, commit_valid, commit_entry.value, count);
      end
    end
  endtask

  task automatic test_two_cdb();
    logic [TAG_W-1:0] tg;
    do_reset();
    for (int i = 0; i < 6; i++) alloc(0, 0, 1, 0, 0, tg);
    alloc(1, 0, 0, 3'd5, 0, tg);
    rd_tag_rs1 = 3'd2;
    #1;
    total++; if (rd_ok_rs1 !== 1'b0) begin bad++; $display("FAIL cdb_pre_ok: got %b want 0", rd_ok_rs1); end
    cdb_valid = 2'b11; cdb_tag = {3'd5, 3'd2}; cdb_value = {32'h99, 32'h22};
    rd_tag_rs2 = 3'd5;
    #1;
    total++; if (rd_ok_rs1 !== 1'b1 || rd_val_rs1 !== 32'h22) begin bad++; $display("FAIL cdb_bypass_rs1: got %b/%0h want 1/22", rd_ok_rs1, rd_val_rs1); end
    total++; if (rd_ok_rs2 !== 1'b1 || rd_val_rs2 !== 32'h99) begin bad++; $display("FAIL cdb_bypass_rs2: got %b/%0h want 1/99", rd_ok_rs2, rd_val_rs2); end
    tick();
    cdb_valid = '0;
    #1;
    total++; if (rd_ok_rs2 !== 1'b1 || rd_val_rs2 !== 32'h99) begin bad++; $display("FAIL cdb_done_tag5: got %b/%0h want 1/99", rd_ok_rs2, rd_val_rs2); end
    rd_tag_rs1 = 3'd6;
    #1;
    total++; if (rd_ok_rs1 !== 1'b1 || rd_val_rs1 !== 32'h99) begin bad++; $display("FAIL store_dep_capture: got %b/%0h want 1/99", rd_ok_rs1, rd_val_rs1); end
    cdb_valid = 2'b11; cdb_tag = {3'd3, 3'd3}; cdb_value = {32'hBB, 32'hAA};
    rd_tag_rs2 = 3'd3;
    tick();
    cdb_valid = '0;
    #1;
    total++; if (rd_val_rs2 !== 32'hBB) begin bad++; $display("FAIL cdb_priority: got %0h want bb", rd_val_rs2); end
  endtask

  task automatic test_branch();
    logic [TAG_W-1:0] tg;
    do_reset();
    alloc(0, 1, 1, 0, 0, tg);
    cdb1(3'd0, 32'h40);
    total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL br_unresolved: got %b want 0", commit_valid); end
    br_valid = 1; br_tag = 3'd0; br_mispredict = 0;
    tick();
    br_valid = 0;
    total++; if (commit_valid !== 1'b1 || count !== 4'd1) begin bad++; $display("FAIL br_resolved: got %b/%0d want 1/1", commit_valid, count); end
  endtask

  task automatic test_mispredict();
    logic [TAG_W-1:0] tg;
    do_reset();
    alloc(0, 0, 1, 0, 0, tg);
    alloc(0, 0, 1, 0, 0, tg);
    alloc(0, 1, 1, 0, 0, tg);
    for (int i = 0; i < 3; i++) alloc(0, 0, 1, 0, 0, tg);
    br_valid = 1; br_tag = 3'd2; br_mispredict = 1;
    cdb_valid = 2'b01; cdb_tag = {3'd0, 3'd4}; cdb_value = {32'd0, 32'h44};
    alloc_valid = 1;
    #1;
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL flush_alloc_ready: got %b want 0", alloc_ready); end
    tick();
    idle_inputs();
    total++; if (count !== 4'd3 || alloc_tag !== 3'd3) begin bad++; $display("FAIL flush_tail: got count=%0d tag=%0d want 3/3", count, alloc_tag); end
    alloc(0, 0, 1, 0, 0, tg);
    total++; if (tg !== 3'd3 || count !== 4'd4) begin bad++; $display("FAIL flush_realloc: got tag=%0d count=%0d want 3/4", tg, count); end
    rd_tag_rs1 = 3'd4; rd_tag_rs2 = 3'd3;
    #1;
    total++; if (rd_ok_rs1 !== 1'b0 || rd_ok_rs2 !== 1'b0) begin bad++; $display("FAIL flush_cdb_dropped: got %b/%b want 0/0", rd_ok_rs1, rd_ok_rs2); end
    cdb1(3'd0, 32'h1);
    cdb1(3'd1, 32'h2);
    cdb1(3'd2, 32'h2c);
    commit_ready = 1;
    for (int i = 0; i < 3; i++) begin
      total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL flush_commit%0d: got %b want 1", i, commit_valid); end
      tick();
    end
    commit_ready = 0;
    total++; if (count !== 4'd1) begin bad++; $display("FAIL flush_commit_count: got %0d want 1", count); end
  endtask

  task automatic test_wrap();
    logic [TAG_W-1:0] tg;
    logic [TAG_W-1:0] exp_tags [4];
    exp_tags[0] = 3'd6; exp_tags[1] = 3'd7; exp_tags[2] = 3'd0; exp_tags[3] = 3'd1;
    do_reset();
    for (int i = 0; i < 6; i++) alloc(0, 0, 1, 0, 0, tg);
    for (int i = 0; i < 6; i++) cdb1(TAG_W'(i), XLEN'(i));
    commit_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    commit_ready = 0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_drain: got %0d want 0", count); end
    for (int i = 0; i < 4; i++) begin
      alloc(0, (i == 1), 1, 0, 0, tg);
      total++; if (tg !== exp_tags[i]) begin bad++; $display("FAIL wrap_tag%0d: got %0d want %0d", i, tg, exp_tags[i]); end
    end
    total++; if (count !== 4'd4) begin bad++; $display("FAIL wrap_count: got %0d want 4", count); end
    br_valid = 1; br_tag = 3'd7; br_mispredict = 1;
    tick();
    idle_inputs();
    total++; if (count !== 4'd2 || alloc_tag !== 3'd0) begin bad++; $display("FAIL wrap_flush: got count=%0d tag=%0d want 2/0", count, alloc_tag); end
  endtask

  task automatic test_load();
    logic [TAG_W-1:0] tg;
    do_reset();
    alloc(0, 0, 1, 0, 0, tg);
    alloc(1, 0, 1, 0, 32'h77, tg);
    alloc(0, 0, 1, 0, 0, tg);
    alloc(0, 0, 1, 0, 0, tg);
    ld_tag = 3'd3; ld_addr = 32'h104;
    #1;
    total++; if (ld_blocked !== 1'b1) begin bad++; $display("FAIL ld_unknown_addr: got %b want 1", ld_blocked); end
    ld_tag = 3'd0;
    #1;
    total++; if (ld_blocked !== 1'b0) begin bad++; $display("FAIL ld_at_head: got %b want 0", ld_blocked); end
    ld_tag = 3'd1;
    #1;
    total++; if (ld_blocked !== 1'b0) begin bad++; $display("FAIL ld_self_store: got %b want 0", ld_blocked); end
    cdb1(3'd1, 32'h100);
    ld_tag = 3'd3; ld_addr = 32'h104;
    #1;
    total++; if (ld_blocked !== 1'b0) begin bad++; $display("FAIL ld_addr_differs: got %b want 0", ld_blocked); end
    ld_addr = 32'h100;
    #1;
    total++; if (ld_blocked !== 1'b1) begin bad++; $display("FAIL ld_addr_equal: got %b want 1", ld_blocked); end
    alloc(0, 0, 1, 0, 0, tg);
    alloc_valid = 1; reset = 1;
    tick();
    reset = 0; alloc_valid = 0;
    total++; if (count !== 4'd0 || ld_blocked !== 1'b0) begin bad++; $display("FAIL reset_mid_fill: got count=%0d blk=%b want 0/0", count, ld_blocked); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_fill();
    test_commit();
    test_two_cdb();
    test_branch();
    test_mispredict();
    test_wrap();
    test_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
